// File: rtl/pop_count_pipe.sv
// pop_count_pipe: pipelined population counter for census-transform vectors.
// A binary adder tree sums adjacent fields level by level; a register stage is
// inserted every LEVELS_PER_STAGE levels and after the final level, so the
// count leaves the block straight from a flop. One global advance enable moves
// the whole pipeline, which gives simple valid/ready backpressure.
// Optional macro CENSUS_POP_COUNT_PIPE_XOR_EN adds in_ref and counts
// in_data ^ in_ref (Hamming distance) with no extra latency.
module pop_count_pipe #(
  parameter int WIDTH            = 64,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
  input  logic [WIDTH-1:0]             in_ref,
`endif
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_count,
  output logic [TAG_WIDTH-1:0]         out_tag
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int N      = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
  localparam int LPS    = (LEVELS_PER_STAGE < 1) ? 1 : LEVELS_PER_STAGE;
  localparam int P      = (N + LPS - 1) / LPS;
  localparam int LEAVES = 1 << N;

  if (WIDTH < 1 || WIDTH > 1024 || LEVELS_PER_STAGE < 1) begin : g_param_check
    $error("pop_count_pipe: WIDTH must be 1..1024 and LEVELS_PER_STAGE >= 1");
  end

  logic                 adv;
  logic                 vld_reg [P];
  logic [TAG_WIDTH-1:0] tag_reg [P];
  logic [WIDTH-1:0]     census;

`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
  assign census = in_data ^ in_ref;
`else
  assign census = in_data;
`endif

  // The pipeline only stalls when a finished result is waiting downstream.
  assign adv       = out_ready || !vld_reg[P-1];
  assign in_ready  = adv;
  assign out_valid = vld_reg[P-1];
  assign out_tag   = tag_reg[P-1];

  // Valid bits and tags travel alongside the tree data, one slot per stage.
  for (genvar gi = 0; gi < P; gi++) begin : g_ctl
    logic                 vld_src;
    logic [TAG_WIDTH-1:0] tag_src;

    if (gi == 0) begin : g_first
      assign vld_src = in_valid;
      assign tag_src = in_tag;
    end else begin : g_rest
      assign vld_src = vld_reg[gi-1];
      assign tag_src = tag_reg[gi-1];
    end

    // Valid bit: cleared by reset so in-flight beats are discarded.
    always_ff @(posedge clk) begin
      if (rst)      vld_reg[gi] <= 1'b0;
      else if (adv) vld_reg[gi] <= vld_src;
    end

    if (gi == P - 1) begin : g_tag_out
      // Output tag register is visible, so it is reset to zero.
      always_ff @(posedge clk) begin
        if (rst)      tag_reg[gi] <= '0;
        else if (adv) tag_reg[gi] <= tag_src;
      end
    end else begin : g_tag_mid
      // Interior tag registers carry no meaning while their valid bit is low.
      always_ff @(posedge clk) begin
        if (adv) tag_reg[gi] <= tag_src;
      end
    end
  end

  // Adder tree. Every node is CW bits wide: a node at level k sums at most
  // min(2^k, WIDTH) ones, which always fits CW, so no level can overflow.
  // Level 0 holds the zero-extended input bits.
  for (genvar gi = 0; gi <= N; gi++) begin : g_lvl
    localparam int NF = LEAVES >> gi;
    logic [CW-1:0] tap [NF];

    if (gi == 0) begin : g_leaf
      for (genvar gj = 0; gj < NF; gj++) begin : g_bit
        if (gj < WIDTH) begin : g_in
          assign tap[gj] = CW'(census[gj]);
        end else begin : g_pad
          assign tap[gj] = '0;
        end
      end
    end else begin : g_node
      logic [CW-1:0] sum [NF];

      for (genvar gj = 0; gj < NF; gj++) begin : g_add
        assign sum[gj] = g_lvl[gi-1].tap[2*gj] + g_lvl[gi-1].tap[2*gj+1];
      end

      if (gi == N) begin : g_out
        logic [CW-1:0] cnt_reg;
        // Final stage register drives out_count directly; reset to zero.
        always_ff @(posedge clk) begin
          if (rst)      cnt_reg <= '0;
          else if (adv) cnt_reg <= sum[0];
        end
        assign tap[0] = cnt_reg;
      end else if (gi % LPS == 0) begin : g_stage
        logic [CW-1:0] val_reg [NF];
        // Intermediate stage register; data needs no reset.
        always_ff @(posedge clk) begin
          if (adv) val_reg <= sum;
        end
        for (genvar gj = 0; gj < NF; gj++) begin : g_fwd
          assign tap[gj] = val_reg[gj];
        end
      end else begin : g_comb
        for (genvar gj = 0; gj < NF; gj++) begin : g_fwd
          assign tap[gj] = sum[gj];
        end
      end
    end
  end

  assign out_count = g_lvl[N].tap[0];

endmodule

// File: tb/tb_pop_count_pipe.sv
// Bench for pop_count_pipe: four instances cover the default geometry,
// an odd width with one level per stage, a one-bit vector and a wide
// randomised run checked against a queue-based reference model.
module tb_pop_count_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference popcount: plain count of set bits.
  function automatic int ref_pop(input logic [1023:0] v);
    int c = 0;
    for (int i = 0; i < 1024; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT A: WIDTH=64, LPS=2 (P=3) ----------------
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0] a_in_data, a_eff;
  logic [7:0]  a_in_tag, a_out_tag;
  logic [6:0]  a_out_count;
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
  logic [63:0] a_in_ref;
  assign a_eff = a_in_data ^ a_in_ref;
`else
  assign a_eff = a_in_data;
`endif

  pop_count_pipe #(.WIDTH(64), .LEVELS_PER_STAGE(2), .TAG_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data),
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
    .in_ref(a_in_ref),
`endif
    .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_count(a_out_count), .out_tag(a_out_tag));

  // ---------------- DUT B: WIDTH=37, LPS=1 (P=6) ----------------
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [36:0] b_in_data;
  logic [7:0]  b_in_tag, b_out_tag;
  logic [5:0]  b_out_count;
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
  logic [36:0] b_in_ref = '0;
`endif

  pop_count_pipe #(.WIDTH(37), .LEVELS_PER_STAGE(1), .TAG_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data),
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
    .in_ref(b_in_ref),
`endif
    .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_count(b_out_count), .out_tag(b_out_tag));

  // ---------------- DUT C: WIDTH=1 (P=1) ----------------
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [0:0]  c_in_data;
  logic [7:0]  c_in_tag, c_out_tag;
  logic [0:0]  c_out_count;
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
  logic [0:0]  c_in_ref = '0;
`endif

  pop_count_pipe #(.WIDTH(1), .LEVELS_PER_STAGE(2), .TAG_WIDTH(8)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data),
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
    .in_ref(c_in_ref),
`endif
    .in_tag(c_in_tag), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_count(c_out_count), .out_tag(c_out_tag));

  // ---------------- DUT D: WIDTH=200, LPS=3 (P=3) ----------------
  logic         d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [199:0] d_in_data, d_eff;
  logic [7:0]   d_in_tag, d_out_tag;
  logic [7:0]   d_out_count;
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
  logic [199:0] d_in_ref;
  assign d_eff = d_in_data ^ d_in_ref;
`else
  assign d_eff = d_in_data;
`endif

  pop_count_pipe #(.WIDTH(200), .LEVELS_PER_STAGE(3), .TAG_WIDTH(8)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data),
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
    .in_ref(d_in_ref),
`endif
    .in_tag(d_in_tag), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_count(d_out_count), .out_tag(d_out_tag));

  // ---------------- scoreboards ----------------
  typedef struct { int cnt; logic [7:0] tag; } exp_t;

  exp_t       a_q[$];
  int         a_in_n = 0, a_out_n = 0;
  logic       a_hold = 1'b0;
  logic [6:0] a_hold_cnt;
  logic [7:0] a_hold_tag;
  exp_t       a_e;

  // A monitor: order/count/tag checks, stall stability and in_ready rule.
  always @(negedge clk) begin
    if (rst) begin
      a_q.delete();
      a_hold <= 1'b0;
    end else begin
      if (a_hold) begin
        check("A stall valid", longint'(a_out_valid), 1);
        check("A stall count", longint'(a_out_count), longint'(a_hold_cnt));
        check("A stall tag", longint'(a_out_tag), longint'(a_hold_tag));
      end
      check("A in_ready", longint'(a_in_ready), longint'(a_out_ready || !a_out_valid));
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          check("A spurious output", 1, 0);
        end else begin
          a_e = a_q.pop_front();
          check("A count", longint'(a_out_count), longint'(a_e.cnt));
          check("A tag", longint'(a_out_tag), longint'(a_e.tag));
          $display("[A] tag=%0d count=%0d", a_out_tag, a_out_count);
        end
        a_out_n <= a_out_n + 1;
      end
      if (a_in_valid && a_in_ready) begin
        a_q.push_back('{ref_pop(1024'(a_eff)), a_in_tag});
        a_in_n <= a_in_n + 1;
      end
      a_hold     <= a_out_valid && !a_out_ready;
      a_hold_cnt <= a_out_count;
      a_hold_tag <= a_out_tag;
    end
  end

  exp_t d_q[$];
  int   d_in_n = 0, d_out_n = 0;
  exp_t d_e;

  // D monitor: reference-model scoreboard for the randomised run.
  always @(negedge clk) begin
    if (rst) begin
      d_q.delete();
    end else begin
      if (d_out_valid && d_out_ready) begin
        if (d_q.size() == 0) begin
          check("D spurious output", 1, 0);
        end else begin
          d_e = d_q.pop_front();
          check("D count", longint'(d_out_count), longint'(d_e.cnt));
          check("D tag", longint'(d_out_tag), longint'(d_e.tag));
          $display("[D] tag=%0d count=%0d", d_out_tag, d_out_count);
        end
        d_out_n <= d_out_n + 1;
      end
      if (d_in_valid && d_in_ready) begin
        d_q.push_back('{ref_pop(1024'(d_eff)), d_in_tag});
        d_in_n <= d_in_n + 1;
      end
    end
  end

  task automatic d_new();
    logic [223:0] r1, r2;
    for (int k = 0; k < 7; k++) begin
      r1[k*32 +: 32] = $urandom;
      r2[k*32 +: 32] = $urandom;
    end
    case ($urandom_range(5))
      0: d_in_data = r1[199:0] & r2[199:0];
      1: d_in_data = r1[199:0] | r2[199:0];
      2: d_in_data = '1;
      3: d_in_data = '0;
      default: d_in_data = r1[199:0];
    endcase
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
    d_in_ref = ($urandom_range(1) == 0) ? '0 : r2[199:0];
`endif
    d_in_tag = 8'($urandom);
  endtask

  // ---------------- directed table ----------------
  typedef struct { logic [63:0] data; logic [63:0] refv; int cnt; } vec_t;
  vec_t vecs[$];

  initial begin
    int sent, cyc, base, acc;
    bit pat [6];

    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_tag = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_data = '0; c_in_tag = '0; c_out_ready = 1;
    d_in_valid = 0; d_in_data = '0; d_in_tag = '0; d_out_ready = 1;
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
    a_in_ref = '0; d_in_ref = '0;
`endif

    vecs.push_back('{64'h0, 64'h0, 0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64});
    vecs.push_back('{64'h8000_0000_0000_0001, 64'h0, 2});
    vecs.push_back('{64'hF0F0_F0F0_F0F0_F0F0, 64'h0, 32});
    vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 63});
    vecs.push_back('{64'h0000_0000_8000_0000, 64'h0, 1});
    vecs.push_back('{64'h0123_4567_89AB_CDEF, 64'h0, 32});
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
    vecs.push_back('{64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 64});
    vecs.push_back('{64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 0});
    vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF1, 1});
`endif

    // Reset values, observed while reset is still held.
    repeat (2) tick();
    check("A reset in_ready", longint'(a_in_ready), 1);
    check("A reset out_valid", longint'(a_out_valid), 0);
    check("A reset out_count", longint'(a_out_count), 0);
    check("A reset out_tag", longint'(a_out_tag), 0);
    check("B reset out_valid", longint'(b_out_valid), 0);
    check("D reset out_valid", longint'(d_out_valid), 0);
    rst = 1'b0;
    tick();
    check("A post-reset in_ready", longint'(a_in_ready), 1);

    // Back-to-back table at full rate; first result exactly 3 cycles later.
    for (int i = 0; i < vecs.size() + 2; i++) begin
      if (i < vecs.size()) begin
        a_in_valid = 1'b1;
        a_in_data  = vecs[i].data;
        a_in_tag   = 8'(i + 16);
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
        a_in_ref   = vecs[i].refv;
`endif
      end else begin
        a_in_valid = 1'b0;
      end
      tick();
      if (i < 2) begin
        check("A table latency", longint'(a_out_valid), 0);
      end else begin
        check("A table valid", longint'(a_out_valid), 1);
        check("A table count", longint'(a_out_count), longint'(vecs[i-2].cnt));
        check("A table tag", longint'(a_out_tag), longint'(i - 2 + 16));
      end
    end
    a_in_valid = 1'b0;
`ifdef CENSUS_POP_COUNT_PIPE_XOR_EN
    a_in_ref = '0;
`endif
    repeat (4) tick();

    // Backpressure: six beats, out_ready pattern 1,0,0,1,0,1 repeating.
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sent = 0; cyc = 0; base = a_out_n;
    a_in_data = {$urandom, $urandom};
    while ((a_out_n - base) < 6 && cyc < 200) begin
      a_out_ready = pat[cyc % 6];
      a_in_valid  = (sent < 6);
      a_in_tag    = 8'(sent + 1);
      @(negedge clk);
      if (a_in_valid && a_in_ready) sent++;
      tick();
      if (a_in_valid && sent == int'(a_in_tag)) a_in_data = {$urandom, $urandom};
      cyc++;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    check("A bp beats sent", sent, 6);
    check("A bp beats out", a_out_n - base, 6);
    check("A bp queue empty", a_q.size(), 0);
    check("A beats in==out", a_in_n, a_out_n);

    // WIDTH=37, one level per stage: 6-cycle latency.
    b_in_valid = 1'b1; b_in_data = '1; b_in_tag = 8'h37;
    tick();
    b_in_data = 37'h1 << 36; b_in_tag = 8'h36;
    tick();
    b_in_valid = 1'b0;
    repeat (3) tick();
    check("B latency", longint'(b_out_valid), 0);
    tick();
    check("B ones valid", longint'(b_out_valid), 1);
    check("B ones count", longint'(b_out_count), 37);
    check("B ones tag", longint'(b_out_tag), 'h37);
    $display("[B] tag=%0d count=%0d", b_out_tag, b_out_count);
    tick();
    check("B bit36 count", longint'(b_out_count), 1);
    check("B bit36 tag", longint'(b_out_tag), 'h36);
    $display("[B] tag=%0d count=%0d", b_out_tag, b_out_count);
    tick();
    check("B drained", longint'(b_out_valid), 0);

    // Reset mid-stream: three beats in flight are discarded.
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1; b_in_data = 37'h1F << i; b_in_tag = 8'(i + 1);
      tick();
    end
    b_in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("B flushed", longint'(b_out_valid), 0);
    end
    b_in_valid = 1'b1; b_in_data = 37'h15; b_in_tag = 8'h99;
    tick();
    b_in_valid = 1'b0;
    repeat (4) tick();
    check("B post-reset latency", longint'(b_out_valid), 0);
    tick();
    check("B post-reset valid", longint'(b_out_valid), 1);
    check("B post-reset count", longint'(b_out_count), 3);
    check("B post-reset tag", longint'(b_out_tag), 'h99);
    $display("[B] tag=%0d count=%0d", b_out_tag, b_out_count);

    // WIDTH=1: single stage.
    check("C idle valid", longint'(c_out_valid), 0);
    c_in_valid = 1'b1; c_in_data = 1'b1; c_in_tag = 8'd1;
    tick();
    check("C one valid", longint'(c_out_valid), 1);
    check("C one count", longint'(c_out_count), 1);
    check("C one tag", longint'(c_out_tag), 1);
    $display("[C] tag=%0d count=%0d", c_out_tag, c_out_count);
    c_in_data = 1'b0; c_in_tag = 8'd2;
    tick();
    check("C zero count", longint'(c_out_count), 0);
    check("C zero tag", longint'(c_out_tag), 2);
    $display("[C] tag=%0d count=%0d", c_out_tag, c_out_count);
    c_in_valid = 1'b0;
    tick();
    check("C drained", longint'(c_out_valid), 0);

    // Randomised run: 10,000 beats, random out_ready.
    acc = 0; cyc = 0;
    d_new();
    while (acc < 10000 && cyc < 60000) begin
      d_in_valid  = 1'b1;
      d_out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      sent = int'(d_in_ready);
      tick();
      cyc++;
      if (sent != 0) begin
        acc++;
        d_new();
      end
    end
    d_in_valid = 1'b0; d_out_ready = 1'b1;
    repeat (10) tick();
    check("D beats accepted", acc, 10000);
    check("D beats in==out", d_in_n, d_out_n);
    check("D queue empty", d_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
